// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared widths, forwarding select codes and stage-record type
package cpu_pkg;

    localparam int REG_BITS = 5;
    localparam int SEL_BITS = 3;

    localparam logic [SEL_BITS-1:0] FWD_REG   = 3'd0;
    localparam logic [SEL_BITS-1:0] FWD_EXMEM = 3'd1;
    localparam logic [SEL_BITS-1:0] FWD_MEMWB = 3'd2;

    typedef struct packed {
        logic                valid;
        logic                wr_en;
        logic [REG_BITS-1:0] dest;
        logic                is_load;
    } stage_rec_t;

    // $0 is hardwired zero, so it can never be a true dependency
    function automatic logic rec_match(stage_rec_t r, logic [REG_BITS-1:0] src, logic use_src);
        return r.valid && r.wr_en && (r.dest == src) && (src != '0) && use_src;
    endfunction

endpackage

// File: rtl/fwd_hazard_ctrl_if.sv
// rtl/fwd_hazard_ctrl_if.sv - decode-side hazard/forwarding bus with master/slave modports
interface fwd_hazard_ctrl_if #(
    parameter int REG_BITS = cpu_pkg::REG_BITS,
    parameter int SEL_BITS = cpu_pkg::SEL_BITS
);
    logic                pipe_en;
    logic                id_valid;
    logic [REG_BITS-1:0] id_rs;
    logic [REG_BITS-1:0] id_rt;
    logic                id_use_rs;
    logic                id_use_rt;
    logic                id_wr_en;
    logic [REG_BITS-1:0] id_wd;
    logic                id_is_load;
    logic                stall;
    logic [SEL_BITS-1:0] fwd_sel_a;
    logic [SEL_BITS-1:0] fwd_sel_b;

    modport master (
        output pipe_en, id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
               id_wr_en, id_wd, id_is_load,
        input  stall, fwd_sel_a, fwd_sel_b
    );

    modport slave (
        input  pipe_en, id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
               id_wr_en, id_wd, id_is_load,
        output stall, fwd_sel_a, fwd_sel_b
    );
endinterface

// File: rtl/fwd_sel_calc.sv
// rtl/fwd_sel_calc.sv - per-operand producer match and youngest-first select priority
module fwd_sel_calc
    import cpu_pkg::*;
(
    input  stage_rec_t          ex_r,
    input  stage_rec_t          mem_r,
    input  logic [REG_BITS-1:0] src,
    input  logic                use_src,
    output logic                ex_hit,
    output logic                mem_hit,
    output logic [SEL_BITS-1:0] sel
);
    always_comb begin
        ex_hit  = rec_match(ex_r, src, use_src);
        mem_hit = rec_match(mem_r, src, use_src);
        sel     = FWD_REG;
        if (ex_hit)
            sel = FWD_EXMEM;
        else if (mem_hit)
            sel = FWD_MEMWB;
    end
endmodule

// File: rtl/fwd_hazard_ctrl.sv
// rtl/fwd_hazard_ctrl.sv - EX operand forwarding and load-use stall control; HAZ_FWD_EN enables forwarding
module fwd_hazard_ctrl
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    fwd_hazard_ctrl_if.slave  bus
);
    stage_rec_t          ex_r, mem_r, wb_r, id_rec;
    logic                ex_hit_a, mem_hit_a, ex_hit_b, mem_hit_b;
    logic [SEL_BITS-1:0] sel_a_nxt, sel_b_nxt;
    logic                stall;
    logic                unused_ok;

    assign id_rec = '{valid: bus.id_valid, wr_en: bus.id_wr_en,
                      dest: bus.id_wd, is_load: bus.id_is_load};

    fwd_sel_calc u_sel_a (
        .ex_r    (ex_r),
        .mem_r   (mem_r),
        .src     (bus.id_rs),
        .use_src (bus.id_use_rs),
        .ex_hit  (ex_hit_a),
        .mem_hit (mem_hit_a),
        .sel     (sel_a_nxt)
    );

    fwd_sel_calc u_sel_b (
        .ex_r    (ex_r),
        .mem_r   (mem_r),
        .src     (bus.id_rt),
        .use_src (bus.id_use_rt),
        .ex_hit  (ex_hit_b),
        .mem_hit (mem_hit_b),
        .sel     (sel_b_nxt)
    );

`ifdef HAZ_FWD_EN
    logic [SEL_BITS-1:0] sel_a_q, sel_b_q;

    // Only a load in EX cannot be bypassed; everything else forwards
    assign stall = bus.id_valid && ex_r.is_load && (ex_hit_a || ex_hit_b);

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_a_q <= FWD_REG;
            sel_b_q <= FWD_REG;
        end else if (bus.pipe_en) begin
            sel_a_q <= stall ? FWD_REG : sel_a_nxt;
            sel_b_q <= stall ? FWD_REG : sel_b_nxt;
        end
    end

    assign bus.fwd_sel_a = sel_a_q;
    assign bus.fwd_sel_b = sel_b_q;
    assign unused_ok     = ^{wb_r, mem_hit_a, mem_hit_b};
`else
    // Without bypass paths, wait until the producer reaches WB
    assign stall = bus.id_valid && (ex_hit_a || ex_hit_b || mem_hit_a || mem_hit_b);

    assign bus.fwd_sel_a = FWD_REG;
    assign bus.fwd_sel_b = FWD_REG;
    assign unused_ok     = ^{wb_r, sel_a_nxt, sel_b_nxt};
`endif

    assign bus.stall = stall;

    // wb_r is tracked but never forwarded: the register file writes before it reads
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_r  <= '0;
            mem_r <= '0;
            wb_r  <= '0;
        end else if (bus.pipe_en) begin
            ex_r  <= stall ? stage_rec_t'('0) : id_rec;
            mem_r <= ex_r;
            wb_r  <= mem_r;
        end
    end
endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// tb/tb_fwd_hazard_ctrl.sv - directed scoreboard bench for fwd_hazard_ctrl
module tb_fwd_hazard_ctrl;
    import cpu_pkg::*;

`ifdef HAZ_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fwd_hazard_ctrl_if bus ();

    fwd_hazard_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int    a;
        int    b;
        string tag;
    } exp_t;

    exp_t sb[$];
    exp_t last;
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic int pick(int with_fwd, int without_fwd);
        return FWD ? with_fwd : without_fwd;
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push(int a, int b, string tag);
        exp_t e;
        e.a = a;
        e.b = b;
        e.tag = tag;
        sb.push_back(e);
        last = e;
    endtask

    // One clock; whatever entered EX on this edge is compared against the scoreboard
    task automatic cycle();
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({e.tag, ".sel_a"}, 32'(bus.fwd_sel_a), e.a);
            check({e.tag, ".sel_b"}, 32'(bus.fwd_sel_b), e.b);
        end
    endtask

    task automatic drive(bit v, int rs, int rt, bit urs, bit urt, bit wr, int wd, bit ld);
        bus.id_valid   = v;
        bus.id_rs      = REG_BITS'(rs);
        bus.id_rt      = REG_BITS'(rt);
        bus.id_use_rs  = urs;
        bus.id_use_rt  = urt;
        bus.id_wr_en   = wr;
        bus.id_wd      = REG_BITS'(wd);
        bus.id_is_load = ld;
    endtask

    task automatic issue(string tag, bit v, int rs, int rt, bit urs, bit urt, bit wr,
                         int wd, bit ld, int nst, int a, int b);
        drive(v, rs, rt, urs, urt, wr, wd, ld);
        bus.pipe_en = 1'b1;
        #1;
        for (int k = 0; k < nst; k++) begin
            check({tag, ".stall"}, 32'(bus.stall), 1);
            push(0, 0, {tag, ".bubble"});
            cycle();
        end
        check({tag, ".go"}, 32'(bus.stall), 0);
        push(a, b, tag);
        cycle();
    endtask

    task automatic alu(string tag, int rd, int rs, int rt, int nst, int a, int b);
        issue(tag, 1'b1, rs, rt, 1'b1, 1'b1, 1'b1, rd, 1'b0, nst, a, b);
    endtask

    task automatic lw(string tag, int rt, int base, int nst, int a, int b);
        issue(tag, 1'b1, base, rt, 1'b1, 1'b0, 1'b1, rt, 1'b1, nst, a, b);
    endtask

    task automatic nop2(string tag);
        issue({tag, ".nop0"}, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 0, 0);
        issue({tag, ".nop1"}, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 0, 0);
    endtask

    task automatic freeze(int n);
        drive(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        bus.pipe_en = 1'b0;
        #1;
        for (int k = 0; k < n; k++) begin
            check("freeze.stall", 32'(bus.stall), 0);
            push(last.a, last.b, "freeze.hold");
            cycle();
        end
        bus.pipe_en = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        bus.pipe_en = 1'b1;
        drive(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("reset.stall", 32'(bus.stall), 0);
        check("reset.sel_a", 32'(bus.fwd_sel_a), 0);
        check("reset.sel_b", 32'(bus.fwd_sel_b), 0);
        rst = 1'b0;

        // $0 never forwards or stalls
        alu("r0.prod", 0, 1, 2, 0, 0, 0);
        alu("r0.cons", 5, 0, 0, 0, 0, 0);
        nop2("r0");

        // EX/MEM forward
        alu("exm.prod", 3, 1, 2, 0, 0, 0);
        alu("exm.cons", 4, 3, 5, pick(0, 2), pick(1, 0), 0);
        nop2("exm");

        // MEM/WB forward
        alu("mwb.prod", 3, 1, 2, 0, 0, 0);
        alu("mwb.indep", 10, 11, 12, 0, 0, 0);
        alu("mwb.cons", 6, 7, 3, pick(0, 1), 0, pick(2, 0));
        nop2("mwb");

        // Load-use
        lw("lu.load", 8, 1, 0, 0, 0);
        alu("lu.cons", 9, 8, 8, pick(1, 2), pick(2, 0), pick(2, 0));
        nop2("lu");

        // Youngest producer wins
        alu("pri.old", 3, 1, 2, 0, 0, 0);
        alu("pri.new", 3, 1, 2, 0, 0, 0);
        alu("pri.cons", 4, 3, 3, pick(0, 2), pick(1, 0), pick(1, 0));
        nop2("pri");

        // Freeze with a live forward in EX, then resume
        alu("frz.prod", 3, 1, 2, 0, 0, 0);
        alu("frz.cons", 4, 3, 5, pick(0, 2), pick(1, 0), 0);
        freeze(3);
        alu("frz.after", 6, 7, 3, 0, 0, pick(2, 0));
        nop2("frz");

        // Reset during a stall
        lw("rst.load", 8, 1, 0, 0, 0);
        drive(1'b1, 8, 8, 1'b1, 1'b1, 1'b1, 9, 1'b0);
        #1;
        check("rst.stall_before", 32'(bus.stall), 1);
        rst = 1'b1;
        cycle();
        check("rst.stall_after", 32'(bus.stall), 0);
        check("rst.sel_a", 32'(bus.fwd_sel_a), 0);
        check("rst.sel_b", 32'(bus.fwd_sel_b), 0);
        rst = 1'b0;
        drive(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        cycle();

        check("sb.drained", 32'(sb.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/fwd_hazard_ctrl.md
Name: fwd_hazard_ctrl

Overview:
- Sequencing controller for the 5-stage MIPS32 pipeline.
- Drives the two 3-way EX-stage operand muxes: A-operand and B-operand.
- Tracks in-flight register writes internally in EX/MEM/WB shadow records, computes forwarding selects, and detects load-use hazards.
- Sits beside the ID/EX pipeline register; its stall output freezes PC and IF/ID.

Parameters:
- REG_BITS, 5, register index width.
- SEL_BITS, 3, forwarding-select width; matches the operand mux select port.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous active-high reset
- pipe_en  in  1  global advance enable; 0 = memory-system freeze, all state held
- id_valid  in  1  ID stage holds a real instruction
- id_rs  in  REG_BITS  source register A index
- id_rt  in  REG_BITS  source register B index
- id_use_rs  in  1  instruction reads rs
- id_use_rt  in  1  instruction reads rt
- id_wr_en  in  1  instruction writes a GPR
- id_wd  in  REG_BITS  destination index
- id_is_load  in  1  instruction is LW/LB/LH class
- stall  out  1  combinational; hold PC and IF/ID, inject bubble into ID/EX
- fwd_sel_a  out  SEL_BITS  registered A-mux select for the instruction now in EX
- fwd_sel_b  out  SEL_BITS  registered B-mux select for the instruction now in EX

Behaviour:
- Select encoding:
  - 0 = register-file value
  - 1 = EX/MEM result
  - 2 = MEM/WB result
  - other codes never driven
- Shadow records ex_r, mem_r, wb_r: each holds {valid, wr_en, dest, is_load}.
- Reset (rst=1 at posedge): all records cleared (valid=0); fwd_sel_a = fwd_sel_b = 0. The stall output is 0 while records are clear. Reset mid-stall cancels the stall on the next cycle.
- Match: record R matches source s when R.valid && R.wr_en && R.dest == s && s != 0 && the use flag is set. Register 0 never forwards and never stalls.
- Load-use stall: stall = id_valid && ex_r.is_load && ex_r matches id_rs or id_rt.
- Next select, per operand:
  - ex_r match -> 1
  - else mem_r match -> 2
  - else 0
  - ex_r has priority over mem_r (youngest producer wins).
- Posedge with pipe_en=1, stall=0:
  - ex_r <= ID info (valid = id_valid)
  - mem_r <= ex_r; wb_r <= mem_r
  - fwd_sel_a/b <= next selects
- Posedge with pipe_en=1, stall=1:
  - ex_r <= bubble (valid=0); mem_r <= ex_r; wb_r <= mem_r
  - fwd_sel_a/b <= 0
  - Exactly one stall cycle per load-use. After it, the load sits in mem_r, so next select = 2.
- Posedge with pipe_en=0: all records and selects hold; stall is still evaluated combinationally.
- Latency: selects are valid during the cycle the consumer occupies EX, one clock after leaving ID.
- wb_r match needs no forwarding: the register file writes in the first half-cycle and reads in the second.
- Consecutive loads to the same register: each consumer stalls independently against the current ex_r.

Optional Feature:
- Macro HAZ_FWD_EN.
- Defined: forwarding as above.
- Undefined:
  - fwd_sel_a/b are constant 0.
  - stall = id_valid && (ex_r or mem_r matches an ID source), regardless of is_load.
  - Stall repeats each cycle until the producer reaches WB (up to 2 cycles).

Decomposition:
- Shared package cpu_pkg holds:
  - FWD_REG = 0, FWD_EXMEM = 1, FWD_MEMWB = 2
  - REG_BITS
  - stage-record struct typedef
- One natural sub-module: fwd_sel_calc, the pure-combinational match/priority logic, instantiated once per operand (A and B).

Test Plan:
- Reset and register 0:
  - rst=1 for 2 cycles -> stall=0, fwd_sel_a=fwd_sel_b=0.
  - Then "addu $0,..." followed by a consumer reading $0 -> selects stay 0.
- EX/MEM forward: "addu $3,$1,$2" then "subu $4,$3,$5" -> consumer in EX has fwd_sel_a=1, fwd_sel_b=0, no stall.
- MEM/WB forward: "addu $3" then an independent op then "or $6,$7,$3" -> fwd_sel_b=2.
- Load-use: "lw $8" then "addu $9,$8,$8":
  - stall=1 for exactly 1 cycle.
  - Bubble enters EX with selects 0.
  - The consumer then enters EX with fwd_sel_a=fwd_sel_b=2.
- Priority: "addu $3", "addu $3", "subu $4,$3,$3" -> selects 1/1 (youngest producer).
- Freeze: pipe_en=0 for 3 cycles mid-sequence -> selects and records unchanged, with forwarding resuming correctly after release.
- Without HAZ_FWD_EN: the case-2 sequence gives stall=1 for 2 cycles and selects always 0.
